// File: rtl/arb_pkg.sv
// Shared constants and width helpers for the PCI arbiter request path.
package arb_pkg;

    localparam int ARB_ID_W   = 3;
    localparam int ARB_QDEPTH = 32;

    // Occupancy must represent 0..depth inclusive, hence depth+1 states.
    function automatic int arb_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/arb_req_match.sv
// Duplicate detector: flags wr_data matching any live entry, ignoring the head when it pops this cycle.
// Purely combinational; no state, no backpressure.
module arb_req_match
    import arb_pkg::*;
#(
    parameter int DATA_W = ARB_ID_W,
    parameter int DEPTH  = ARB_QDEPTH,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = arb_cnt_w(DEPTH)
) (
    input  logic [DATA_W-1:0] mem [DEPTH],
    input  logic [PTR_W-1:0]  rd_ptr,
    input  logic [CNT_W-1:0]  count,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic              hit
);

    always_comb begin
        logic [PTR_W-1:0] offset;
        hit    = 1'b0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Distance from the head decides whether slot i is live.
            offset = PTR_W'(i) - rd_ptr;
            if ((CNT_W'(offset) < count) && (!pop || (offset != '0)) && (mem[i] == wr_data)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_req_queue.sv
// FWFT request-ID queue for the PCI arbiter; pop latency 1, pushed data visible the next cycle.
// Backpressure: full blocks a push unless a pop happens that cycle; a blocked push sets sticky overflow.
module arb_req_queue
    import arb_pkg::*;
#(
    parameter int DATA_W       = ARB_ID_W,
    parameter int DEPTH        = ARB_QDEPTH,
    parameter int AFULL_THRESH = 30,
    parameter int DEDUP        = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rd_en,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_full,
    output logic [arb_cnt_w(DEPTH)-1:0] count,
    output logic                        dup_drop,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = arb_cnt_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pop;
    logic              hit;
    logic              push;
    logic              blocked;
    logic [CNT_W-1:0]  count_nxt;

    assign pop = rd_en && !empty;

    generate
        if (DEDUP != 0) begin : g_dedup
            logic match;
            arb_req_match #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH),
                .PTR_W  (PTR_W),
                .CNT_W  (CNT_W)
            ) u_match (
                .mem     (mem),
                .rd_ptr  (rd_ptr),
                .count   (count),
                .pop     (pop),
                .wr_data (wr_data),
                .hit     (match)
            );
            assign hit = wr_en && match;
        end else begin : g_no_dedup
            assign hit = 1'b0;
        end
    endgenerate

    // A deduplicated write never counts as blocked, even when full.
    assign push      = wr_en && !hit && (!full || pop);
    assign blocked   = wr_en && !hit && full && !pop;
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            dup_drop    <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count       <= count_nxt;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == CNT_W'(DEPTH));
            almost_full <= (count_nxt >= CNT_W'(AFULL_THRESH));
            dup_drop    <= hit;
            if (blocked) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_arb_req_queue.sv
// Bench: two queue instances (DEDUP=0 and DEDUP=1) driven in lockstep, each checked against a shift-array model.
module tb_arb_req_queue;

    localparam int DW    = 3;
    localparam int DEPTH = 32;
    localparam int AFT   = 30;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;

    logic [DW-1:0] rd_data0, rd_data1;
    logic          empty0, empty1, full0, full1, afull0, afull1;
    logic [5:0]    count0, count1;
    logic          dup0, dup1, ovf0, ovf1, unf0, unf1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: index 0 is always the oldest entry; pops shift the array.
    logic [DW-1:0] mq [2][DEPTH];
    int            msz [2];
    bit            movf [2];
    bit            munf [2];
    bit            mdup [2];

    always #5 clk = ~clk;

    arb_req_queue #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFT), .DEDUP(0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data0), .empty(empty0), .full(full0), .almost_full(afull0), .count(count0),
        .dup_drop(dup0), .overflow(ovf0), .underflow(unf0)
    );

    arb_req_queue #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFT), .DEDUP(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data1), .empty(empty1), .full(full1), .almost_full(afull1), .count(count1),
        .dup_drop(dup1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int m, input bit ded, input bit w, input int d,
                              input bit r, input bit f, input bit rs);
        bit popping;
        bit hit;
        bit acc;
        if (rs || f) begin
            msz[m]  = 0;
            movf[m] = 0;
            munf[m] = 0;
            mdup[m] = 0;
        end else begin
            popping = r && (msz[m] > 0);
            hit     = 0;
            acc     = 0;
            if (r && msz[m] == 0) munf[m] = 1;
            if (ded && w) begin
                for (int j = (popping ? 1 : 0); j < msz[m]; j++)
                    if (int'(mq[m][j]) == d) hit = 1;
            end
            mdup[m] = w && hit;
            if (w && !hit) begin
                if (msz[m] == DEPTH && !popping) movf[m] = 1;
                else acc = 1;
            end
            if (popping) begin
                for (int j = 0; j < msz[m] - 1; j++) mq[m][j] = mq[m][j + 1];
                msz[m]--;
            end
            if (acc) begin
                mq[m][msz[m]] = DW'(d);
                msz[m]++;
            end
        end
    endtask

    task automatic check_dut(input int m);
        int exp_rd;
        exp_rd = (msz[m] > 0) ? int'(mq[m][0]) : 0;
        check($sformatf("u%0d.count", m),     m == 0 ? int'(count0)   : int'(count1),   msz[m]);
        check($sformatf("u%0d.empty", m),     m == 0 ? int'(empty0)   : int'(empty1),   int'(msz[m] == 0));
        check($sformatf("u%0d.full", m),      m == 0 ? int'(full0)    : int'(full1),    int'(msz[m] == DEPTH));
        check($sformatf("u%0d.afull", m),     m == 0 ? int'(afull0)   : int'(afull1),   int'(msz[m] >= AFT));
        check($sformatf("u%0d.rd_data", m),   m == 0 ? int'(rd_data0) : int'(rd_data1), exp_rd);
        check($sformatf("u%0d.dup_drop", m),  m == 0 ? int'(dup0)     : int'(dup1),     int'(mdup[m]));
        check($sformatf("u%0d.overflow", m),  m == 0 ? int'(ovf0)     : int'(ovf1),     int'(movf[m]));
        check($sformatf("u%0d.underflow", m), m == 0 ? int'(unf0)     : int'(unf1),     int'(munf[m]));
    endtask

    // One clock: drive inputs, update the model at the edge, check 1 time unit later.
    task automatic cyc(input bit w, input int d, input bit r, input bit f = 0, input bit rs = 0);
        wr_en   = w;
        wr_data = DW'(d);
        rd_en   = r;
        flush   = f;
        rst     = rs;
        @(posedge clk);
        model_step(0, 0, w, d, r, f, rs);
        model_step(1, 1, w, d, r, f, rs);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    initial begin
        int pw;
        int pr;
        cyc(0, 0, 0, 0, 1);
        check("reset.empty0", int'(empty0), 1);

        // Basic order
        for (int i = 0; i < 4; i++) cyc(1, i, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);

        // Fill, overflow, wrap
        for (int i = 0; i < 32; i++) cyc(1, i % 8, 0);
        check("fill.full0", int'(full0), 1);
        cyc(1, 0, 0);
        check("fill.ovf0", int'(ovf0), 1);
        check("fill.cnt0", int'(count0), 32);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1);
        for (int i = 0; i < 16; i++) cyc(1, (i + 3) % 8, 0);

        // Simultaneous push/pop when full, then drain
        cyc(1, 5, 1);
        check("fullpp.cnt0", int'(count0), 32);
        for (int i = 0; i < 32; i++) cyc(0, 0, 1);
        cyc(0, 0, 0, 1);

        // Simultaneous push/pop when empty
        cyc(1, 6, 1);
        check("emptypp.unf0", int'(unf0), 1);
        check("emptypp.rd0", int'(rd_data0), 6);
        cyc(0, 0, 1);

        // Dedup
        cyc(0, 0, 0, 1);
        cyc(1, 2, 0);
        cyc(1, 4, 0);
        cyc(1, 4, 0);
        check("dedup.pulse1", int'(dup1), 1);
        cyc(0, 0, 0);
        cyc(1, 2, 1);
        check("dedup.cnt1", int'(count1), 2);
        cyc(0, 0, 1);
        check("dedup.head1", int'(rd_data1), 2);

        // Flush and reset with pending data and sticky overflow
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 1);
            for (int i = 0; i < 33; i++) cyc(1, i % 8, 0);
            for (int i = 0; i < 25; i++) cyc(0, 0, 1);
            check("clr.pre_cnt0", int'(count0), 7);
            if (k == 0) cyc(1, 3, 0, 1, 0);
            else        cyc(1, 3, 0, 0, 1);
            check("clr.cnt0", int'(count0), 0);
            check("clr.ovf0", int'(ovf0), 0);
        end

        // Randomized phases with differing write/read pressure
        for (int ph = 0; ph < 5; ph++) begin
            case (ph)
                0: begin pw = 80; pr = 40; end
                1: begin pw = 50; pr = 50; end
                2: begin pw = 95; pr = 10; end
                3: begin pw = 20; pr = 80; end
                default: begin pw = 60; pr = 55; end
            endcase
            for (int i = 0; i < 800; i++) begin
                cyc(($urandom_range(99) < pw), $urandom_range(7), ($urandom_range(99) < pr),
                    ($urandom_range(499) == 0), ($urandom_range(999) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_req_queue.md
Name: arb_req_queue

Overview:
Parametrised request queue for the PCI arbiter. It holds master request IDs in arrival order and presents the oldest to the grant logic in first-word-fall-through (FWFT) mode. It is the single-edge, resettable successor of the arbiter's address FIFO. New features: arbitrary width and depth, simultaneous push and pop, optional duplicate-request suppression, an almost-full threshold, a live occupancy count, sticky overflow/underflow flags and a synchronous flush.

Parameters:
DATA_W, 3, width of a request ID (master address)
DEPTH, 32, number of entries; power of two, >= 4
AFULL_THRESH, 30, almost_full asserts when count >= AFULL_THRESH; range 1..DEPTH
DEDUP, 1, 1 = drop a write whose data equals any queued entry; 0 = accept all writes

Ports:
clk  in  1  system clock; all state updates on rising edge only
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous queue clear
wr_en  in  1  push request
wr_data  in  DATA_W  ID to push
rd_en  in  1  pop the head entry
rd_data  out  DATA_W  head entry (FWFT); value 0 when empty
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AFULL_THRESH
count  out  $clog2(DEPTH+1)  current occupancy
dup_drop  out  1  one-cycle pulse: a write was dropped by DEDUP
overflow  out  1  sticky: write attempted while full and no pop
underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Storage and pointers:
  - Circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping naturally DEPTH-1 -> 0.
  - Count register is separate. No data shifting.
- Reset (rst=1 at posedge), highest priority:
  - wr_ptr = rd_ptr = count = 0.
  - empty=1, full=0, almost_full=0, dup_drop=0, overflow=0, underflow=0, rd_data=0.
  - Storage contents are don't-care.
- Flush (rst=0, flush=1):
  - Same effect as reset, including clearing the sticky flags.
  - wr_en and rd_en are ignored that cycle.
- Pop: rd_en=1 and count>0.
  - rd_ptr advances and count decrements.
  - rd_data shows the new head the next cycle, so pop latency is 1.
- Push: wr_en=1, accepted when not blocked.
  - Data is written at wr_ptr, wr_ptr advances and count increments.
  - First data is visible on rd_data one cycle after a push into an empty queue; there is no same-cycle bypass.
- Push blocking (overflow):
  - A push is blocked when full=1 and no pop happens that cycle.
  - A blocked push sets overflow; the data is discarded.
- Simultaneous push and pop:
  - Both are performed and count is unchanged.
  - This is legal when full: no overflow, wr_ptr and rd_ptr both advance.
  - When empty, the pop sets underflow and has no other effect; the push is still accepted and count becomes 1.
- DEDUP=1:
  - wr_data is compared against every valid entry, i.e. the entries in [rd_ptr, rd_ptr+count).
  - Exception: if a pop occurs in the same cycle, the head entry is excluded from the comparison.
  - On a match the write is not stored, pointers and count are unchanged, dup_drop pulses for one cycle, and overflow is not set, even if full.
  - When the queue is empty, no match is possible.
- DEDUP=0: no comparison; dup_drop is tied to 0.
- Registered vs derived outputs:
  - empty, full, almost_full and count are registered and consistent with each other every cycle.
  - rd_data is read combinationally from the storage at rd_ptr and forced to 0 when empty.
- Sticky flags: overflow and underflow stay set until rst or flush.
- Status updates: all status outputs reflect the post-edge state; a status change appears the cycle after the causing edge.

Decomposition:
- Package arb_pkg holds:
  - ARB_ID_W = 3 and ARB_QDEPTH = 32, used as defaults for DATA_W and DEPTH.
  - The count-width constant derivation.
- Sub-module arb_req_match (natural split):
  - Inputs: storage array, rd_ptr, count, pop-this-cycle flag and wr_data.
  - Output: one-bit hit.
  - Purely combinational; it isolates the DEPTH-wide compare for timing and reuse.

Test Plan:
- Reset/basic order: rst 1 cycle, then push 0,1,2,3 on consecutive cycles, then pop 4 cycles -> rd_data sequence 0,1,2,3, empty=1 after the last pop, count 4 -> 0, no flags.
- Fill and wrap (DEDUP=0, DEPTH=32, AFULL_THRESH=30):
  - Push 32 entries with values i mod 8 -> almost_full at count 30, full at 32.
  - A 33rd push -> overflow=1, count stays 32.
  - Pop 16, push 16 -> pointers wrap and the FIFO order is preserved.
- Simultaneous push/pop:
  - When full, push 5 and pop together -> count stays 32, no overflow, and 5 is popped last.
  - When empty, push 6 and pop together -> underflow=1, count=1, rd_data=6 next cycle.
- Dedup (DEDUP=1):
  - Push 2,4 then push 4 -> dup_drop pulse, count=2.
  - Push 2 while popping head 2 -> accepted, count stays 2, queue becomes 4,2.
- Flush/reset mid-operation: with count=7 and overflow=1, assert flush together with wr_en -> next cycle count=0, empty=1, overflow=0, and the write is ignored. Repeat the same check using rst.
